z16_dmem_arbiter: RTL and testbench
===================================

// Module: z16_dmem_arbiter
// PURPOSE
//  Shares the single Z16DataMem port between two requesters: requester 0 (Z16CPU load/store
//  path) and requester 1 (program loader / debug port). Owner-based round-robin with a
//  bounded burst length, so neither side starves. Sits between the requesters and the
//  Z16DataMem i_addr/i_wen/i_data/o_data pins. Registers read data back to the issuer.
// PARAMETERS
//  AW         16  address width (matches Z16DataMem i_addr)
//  DW         16  data width
//  MAX_BURST  4   max consecutive accepted transfers for one owner while the other waits (>=1)
// PORTS
//  i_clk          in   1   clock; all state updates on posedge
//  i_rst          in   1   synchronous, active-high reset
//  i_reqN_valid   in   1   requester N (N=0,1) has a transfer pending
//  i_reqN_wen     in   1   1=write, 0=read
//  i_reqN_addr    in   AW  transfer address
//  i_reqN_wdata   in   DW  write data
//  o_reqN_ready   out  1   transfer accepted this cycle when valid&ready
//  o_reqN_rvalid  out  1   read data for requester N valid (1 cycle after read accept)
//  o_reqN_rdata   out  DW  registered read data
//  o_mem_addr     out  AW  to Z16DataMem i_addr
//  o_mem_wen      out  1   to Z16DataMem i_wen
//  o_mem_data     out  DW  to Z16DataMem i_data
//  i_mem_data     in   DW  from Z16DataMem o_data (combinational read of o_mem_addr)
// BEHAVIOUR
//  - Reset: state=IDLE, last-served pointer=1 (req0 preferred first), burst count=0,
//    all o_reqN_ready/o_reqN_rvalid=0, o_reqN_rdata=0, o_mem_wen=0, o_mem_addr/o_mem_data=0.
//  - FSM states IDLE, OWN0, OWN1. Only the owner sees ready; ready = (state==OWNn), comb.
//  - IDLE: no ready. Next: one valid -> OWN of that one; both -> OWN of requester != last-served;
//    none -> IDLE. Acquisition costs exactly one bubble cycle.
//  - OWNn: each cycle with i_reqN_valid=1 is one accepted transfer; burst count += 1.
//    Owner valid=0 -> IDLE, count cleared, last-served=n.
//    count reaches MAX_BURST with other valid=1 -> OWN(other) directly, count=0, last-served=n.
//    count reaches MAX_BURST with other idle -> stay, count saturates (no wrap) and resets to 0.
//  - Mem drive: o_mem_addr/o_mem_data = owner's addr/wdata when owner valid; o_mem_wen = owner
//    valid & owner wen & state==OWNn. o_mem_wen never asserts in IDLE or for non-owner.
//  - Reads: accepted read at cycle t -> o_reqN_rdata <= i_mem_data, o_reqN_rvalid=1 at t+1 for
//    exactly one cycle per read. Back-to-back reads give back-to-back rvalid. Writes never
//    raise rvalid. rdata holds last value when rvalid=0.
//  - Ownership switch mid-stream: rvalid for old owner's last read still issued at t+1,
//    independent of new owner's activity.
//  - Non-owner valid may stay high indefinitely; its inputs are ignored until granted.
//  - Reset mid-burst: pending rvalid dropped (no response), state IDLE, in-flight write in the
//    reset cycle is not performed (o_mem_wen=0 while i_rst=1).
//  - Address passed unchanged (no alignment check; bit0 handling is Z16DataMem's).
// STRUCTURE
//  - Shared package z16_pkg: arbiter state encoding (IDLE/OWN0/OWN1), requester ID constants
//    REQ_CPU=0, REQ_LDR=1, Z16 AW/DW constants.
//  - One sub-module: z16_burst_counter (clear/incr/saturate at MAX_BURST, limit flag).
//  - Response path (rvalid/rdata regs) kept inline, one set per requester.
// TESTING
//  1 req0 read A=0x0010 alone, mem returns 0x1234 -> ready at cycle 2 (IDLE bubble), rvalid0=1
//    with rdata0=0x1234 at cycle 3, rvalid1 never 1.
//  2 req1 writes 0x00A0<=0xBEEF -> o_mem_wen=1, addr=0x00A0, data=0xBEEF for exactly one cycle.
//  3 both valid continuously, MAX_BURST=4 -> grant pattern 4x req0, 4x req1, 4x req0, ... no
//    IDLE bubble at switches; count of mem_wen/reads per owner = 4.
//  4 req0 sole requester for 10 transfers -> stays OWN0, 10 accepts, no stall at count 4.
//  5 both valid from IDLE after req1 last served -> req0 granted first; after req0 last
//    served -> req1 granted first.
//  6 i_rst asserted the cycle after a read accept -> no rvalid, all outputs 0, next grant needs
//    IDLE bubble.

Source files
------------

// File: rtl/z16_pkg.sv
// Shared Z16 definitions for the data-memory arbiter.
//   Z16_AW / Z16_DW   : Z16DataMem address / data widths
//   REQ_CPU / REQ_LDR : requester IDs (CPU load/store path, loader/debug port)
//   arb_state_e       : arbiter ownership state
package z16_pkg;

  localparam int Z16_AW = 16;
  localparam int Z16_DW = 16;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  // Ownership state that grants the given requester ID.
  function automatic arb_state_e own_state(input logic id);
    return (id == REQ_LDR) ? ARB_OWN1 : ARB_OWN0;
  endfunction

endpackage

// File: rtl/z16_burst_counter.sv
// Counts consecutive accepted transfers for the current owner.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clr        : drop the running burst (no transfer this cycle)
//   i_incr       : one transfer accepted this cycle
//   o_limit      : this accept is the MAX_BURST-th of the burst
// The counter never stores MAX_BURST: the accept that completes a burst
// returns it to 0, so the count cannot wrap and a fresh burst starts cleanly.
module z16_burst_counter #(
  parameter int MAX_BURST = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_incr,
  output logic o_limit
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign o_limit = i_incr && (count_q == CW'(MAX_BURST - 1));

  always_comb begin
    count_d = count_q;
    if (i_clr || o_limit) begin
      count_d = '0;
    end else if (i_incr) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/z16_dmem_arbiter.sv
// Shares the single Z16DataMem port between the CPU load/store path (req0)
// and the program loader / debug port (req1) using owner-based round robin
// with a bounded burst length.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ARB_IDLE | no owner, no ready; picks next owner (one bubble cycle)
// ARB_OWN0 | req0 owns the memory port, ready0 high
// ARB_OWN1 | req1 owns the memory port, ready1 high
//
// Ports:
//   i_clk, i_rst                    clock, synchronous active-high reset
//   i_reqN_valid/wen/addr/wdata     requester N transfer request
//   o_reqN_ready                    transfer accepted when valid & ready
//   o_reqN_rvalid/rdata             registered read response (1 cycle later)
//   o_mem_addr/wen/data, i_mem_data Z16DataMem pins (combinational read)
module z16_dmem_arbiter
  import z16_pkg::*;
#(
  parameter int AW        = Z16_AW,
  parameter int DW        = Z16_DW,
  parameter int MAX_BURST = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,

  input  logic          i_req0_valid,
  input  logic          i_req0_wen,
  input  logic [AW-1:0] i_req0_addr,
  input  logic [DW-1:0] i_req0_wdata,
  output logic          o_req0_ready,
  output logic          o_req0_rvalid,
  output logic [DW-1:0] o_req0_rdata,

  input  logic          i_req1_valid,
  input  logic          i_req1_wen,
  input  logic [AW-1:0] i_req1_addr,
  input  logic [DW-1:0] i_req1_wdata,
  output logic          o_req1_ready,
  output logic          o_req1_rvalid,
  output logic [DW-1:0] o_req1_rdata,

  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_wen,
  output logic [DW-1:0] o_mem_data,
  input  logic [DW-1:0] i_mem_data
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;

  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic own0, own1;
  logic acc0, acc1, accept;
  logic owner_id, owner_valid, other_valid;
  logic burst_limit;

  // Ownership is masked during reset so nothing is accepted (and no write
  // reaches memory) in a cycle that is being reset.
  assign own0   = (state_q == ARB_OWN0) && !i_rst;
  assign own1   = (state_q == ARB_OWN1) && !i_rst;
  assign acc0   = own0 && i_req0_valid;
  assign acc1   = own1 && i_req1_valid;
  assign accept = acc0 || acc1;

  assign o_req0_ready = own0;
  assign o_req1_ready = own1;

  assign owner_id    = (state_q == ARB_OWN1) ? REQ_LDR : REQ_CPU;
  assign owner_valid = (owner_id == REQ_LDR) ? i_req1_valid : i_req0_valid;
  assign other_valid = (owner_id == REQ_LDR) ? i_req0_valid : i_req1_valid;

  // Any cycle without an accepted transfer ends the current burst.
  z16_burst_counter #(
    .MAX_BURST (MAX_BURST)
  ) u_burst (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (!accept),
    .i_incr  (accept),
    .o_limit (burst_limit)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (i_req0_valid && i_req1_valid) begin
          state_d = own_state(~last_q);
        end else if (i_req0_valid) begin
          state_d = ARB_OWN0;
        end else if (i_req1_valid) begin
          state_d = ARB_OWN1;
        end
      end
      ARB_OWN0, ARB_OWN1: begin
        if (!owner_valid) begin
          state_d = ARB_IDLE;
          last_d  = owner_id;
        end else if (burst_limit && other_valid) begin
          // Hand over directly: no idle bubble on a burst-limit switch.
          state_d = own_state(~owner_id);
          last_d  = owner_id;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    o_mem_addr = '0;
    o_mem_data = '0;
    o_mem_wen  = 1'b0;
    if (acc0) begin
      o_mem_addr = i_req0_addr;
      o_mem_data = i_req0_wdata;
      o_mem_wen  = i_req0_wen;
    end else if (acc1) begin
      o_mem_addr = i_req1_addr;
      o_mem_data = i_req1_wdata;
      o_mem_wen  = i_req1_wen;
    end
  end

  // Read data is captured from the combinational memory read in the accept
  // cycle; it stays with the issuer even if ownership moves on.
  always_comb begin
    rvalid0_d = acc0 && !i_req0_wen;
    rvalid1_d = acc1 && !i_req1_wen;
    rdata0_d  = rvalid0_d ? i_mem_data : rdata0_q;
    rdata1_d  = rvalid1_d ? i_mem_data : rdata1_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ARB_IDLE;
      last_q    <= REQ_LDR;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  // A response due in a reset cycle is dropped rather than delivered.
  assign o_req0_rvalid = rvalid0_q && !i_rst;
  assign o_req1_rvalid = rvalid1_q && !i_rst;
  assign o_req0_rdata  = i_rst ? '0 : rdata0_q;
  assign o_req1_rdata  = i_rst ? '0 : rdata1_q;

endmodule

// File: tb/tb_z16_dmem_arbiter.sv
module tb_z16_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_wen, req1_valid, req1_wen;
  logic [15:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic        ready0, ready1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic [15:0] mem_addr, mem_data, mem_rdata;
  logic        mem_wen;

  logic [15:0] tb_mem    [256];
  logic [15:0] model_mem [256];
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] mon_exp0, mon_exp1;
  logic [68:0] all_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  z16_dmem_arbiter #(.AW(16), .DW(16), .MAX_BURST(4)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req0_valid  (req0_valid),
    .i_req0_wen    (req0_wen),
    .i_req0_addr   (req0_addr),
    .i_req0_wdata  (req0_wdata),
    .o_req0_ready  (ready0),
    .o_req0_rvalid (rvalid0),
    .o_req0_rdata  (rdata0),
    .i_req1_valid  (req1_valid),
    .i_req1_wen    (req1_wen),
    .i_req1_addr   (req1_addr),
    .i_req1_wdata  (req1_wdata),
    .o_req1_ready  (ready1),
    .o_req1_rvalid (rvalid1),
    .o_req1_rdata  (rdata1),
    .o_mem_addr    (mem_addr),
    .o_mem_wen     (mem_wen),
    .o_mem_data    (mem_data),
    .i_mem_data    (mem_rdata)
  );

  assign all_out = {ready0, ready1, rvalid0, rvalid1, rdata0, rdata1, mem_wen, mem_addr, mem_data};

  function automatic logic [15:0] pat(input int i);
    if (i == 16) return 16'h1234;
    return 16'(i * 263) ^ 16'h5A5A;
  endfunction

  // Memory the DUT talks to: combinational read, write on posedge, refilled on reset.
  assign mem_rdata = tb_mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= pat(i);
    end else if (mem_wen) begin
      tb_mem[mem_addr[7:0]] <= mem_data;
    end
  end

  // Scoreboard: every read response is matched against the oldest expected value.
  always @(negedge clk) begin
    if (rvalid0 === 1'b1) begin
      n_tests++;
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL rvalid0_unexpected: rvalid0=1 rdata0=%h, required no response", rdata0);
      end else begin
        mon_exp0 = q0.pop_front();
        if (rdata0 !== mon_exp0) begin
          n_fail++;
          $display("FAIL rdata0: got %h, required %h", rdata0, mon_exp0);
        end
      end
    end
    if (rvalid1 === 1'b1) begin
      n_tests++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL rvalid1_unexpected: rvalid1=1 rdata1=%h, required no response", rdata1);
      end else begin
        mon_exp1 = q1.pop_front();
        if (rdata1 !== mon_exp1) begin
          n_fail++;
          $display("FAIL rdata1: got %h, required %h", rdata1, mon_exp1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) model_mem[i] = pat(i);
  endtask

  // Called at a negedge: record accepted transfers in the model / expected queues.
  task automatic note_accepts();
    if (ready0 === 1'b1 && req0_valid) begin
      if (req0_wen) model_mem[req0_addr[7:0]] = req0_wdata;
      else q0.push_back(model_mem[req0_addr[7:0]]);
    end
    if (ready1 === 1'b1 && req1_valid) begin
      if (req1_wen) model_mem[req1_addr[7:0]] = req1_wdata;
      else q1.push_back(model_mem[req1_addr[7:0]]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 0; req0_wen = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_wen = 0; req1_addr = '0; req1_wdata = '0;
    model_reset();
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0", all_out);
    end
  endtask

  task automatic test_read_alone();
    step();
    req0_valid = 1; req0_wen = 0; req0_addr = 16'h0010;
    @(negedge clk);
    n_tests++;
    if (ready0 !== 1'b0) begin n_fail++; $display("FAIL read_bubble: ready0=%b, required 0", ready0); end
    step();
    @(negedge clk);
    n_tests++;
    if (ready0 !== 1'b1) begin n_fail++; $display("FAIL read_grant: ready0=%b, required 1", ready0); end
    n_tests++;
    if (mem_addr !== 16'h0010 || mem_wen !== 1'b0) begin
      n_fail++;
      $display("FAIL read_mem_drive: addr=%h wen=%b, required addr=0010 wen=0", mem_addr, mem_wen);
    end
    note_accepts();
    step();
    req0_valid = 0;
    @(negedge clk);
    n_tests++;
    if (rvalid0 !== 1'b1) begin n_fail++; $display("FAIL read_rvalid_t1: rvalid0=%b, required 1", rvalid0); end
    step();
    @(negedge clk);
    n_tests++;
    if (rvalid0 !== 1'b0) begin n_fail++; $display("FAIL read_rvalid_once: rvalid0=%b, required 0", rvalid0); end
  endtask

  task automatic test_write();
    int  wen_seen = 0;
    logic got = 0;
    step();
    req1_valid = 1; req1_wen = 1; req1_addr = 16'h00A0; req1_wdata = 16'hBEEF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_wen === 1'b1) wen_seen++;
      if (ready1 === 1'b1 && !got) begin
        got = 1;
        n_tests++;
        if (mem_wen !== 1'b1 || mem_addr !== 16'h00A0 || mem_data !== 16'hBEEF) begin
          n_fail++;
          $display("FAIL write_drive: wen=%b addr=%h data=%h, required 1/00a0/beef", mem_wen, mem_addr, mem_data);
        end
        note_accepts();
      end
      step();
      if (got) req1_valid = 0;
    end
    n_tests++;
    if (wen_seen != 1) begin n_fail++; $display("FAIL write_wen_cycles: got %0d, required 1", wen_seen); end
    got = 0;
    req1_valid = 1; req1_wen = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      if (ready1 === 1'b1) begin got = 1; note_accepts(); end
      step();
    end
    req1_valid = 0;
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL write_readback_grant: no ready1, required grant within 6 cycles"); end
    step(); step();
  endtask

  task automatic test_round_robin();
    int   cnt0 = 0, cnt1w = 0, bad_wen = 0;
    logic [1:0] exp_g;
    logic a0, a1;
    step();
    req0_valid = 1; req0_wen = 0; req0_addr = 16'h0020;
    req1_valid = 1; req1_wen = 1; req1_addr = 16'h0040; req1_wdata = 16'hC000;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      exp_g = (c == 0) ? 2'b00 : ((((c - 1) / 4) % 2) == 0 ? 2'b01 : 2'b10);
      n_tests++;
      if ({ready1, ready0} !== exp_g) begin
        n_fail++;
        $display("FAIL rr_grant cycle %0d: {ready1,ready0}=%b, required %b", c, {ready1, ready0}, exp_g);
      end
      a0 = (ready0 === 1'b1);
      a1 = (ready1 === 1'b1);
      if (a0) cnt0++;
      if (a1 && mem_wen === 1'b1 && mem_addr === req1_addr && mem_data === req1_wdata) cnt1w++;
      if (a0 && mem_wen !== 1'b0) bad_wen++;
      note_accepts();
      step();
      if (a0) req0_addr++;
      if (a1) begin req1_addr++; req1_wdata++; end
    end
    req0_valid = 0; req1_valid = 0;
    n_tests++;
    if (cnt0 != 12 || cnt1w != 12 || bad_wen != 0) begin
      n_fail++;
      $display("FAIL rr_counts: reads0=%0d writes1=%0d badwen=%0d, required 12/12/0", cnt0, cnt1w, bad_wen);
    end
    step(); step(); step();
  endtask

  task automatic test_sole_owner();
    int acc = 0, cyc = 0;
    logic a0;
    step();
    req0_valid = 1; req0_wen = 0; req0_addr = 16'h0060;
    while (acc < 10 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      a0 = (ready0 === 1'b1);
      if (a0) acc++;
      note_accepts();
      step();
      if (a0) req0_addr++;
      if (acc == 10) req0_valid = 0;
    end
    req0_valid = 0;
    n_tests++;
    if (acc != 10 || cyc != 11) begin
      n_fail++;
      $display("FAIL sole_throughput: accepts=%0d cycles=%0d, required 10/11", acc, cyc);
    end
    step(); step();
  endtask

  task automatic first_grant(output logic [1:0] g);
    logic got = 0;
    g = 2'b00;
    step();
    req0_valid = 1; req0_wen = 0; req0_addr = 16'h0070;
    req1_valid = 1; req1_wen = 0; req1_addr = 16'h0078;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if ((ready0 | ready1) === 1'b1) begin
        got = 1;
        g = {ready1, ready0};
        note_accepts();
      end
      step();
    end
    req0_valid = 0; req1_valid = 0;
    step(); step();
  endtask

  task automatic test_priority();
    logic [1:0] g;
    first_grant(g);
    n_tests++;
    if (g !== 2'b10) begin n_fail++; $display("FAIL prio_after_req0: grant=%b, required 10", g); end
    first_grant(g);
    n_tests++;
    if (g !== 2'b01) begin n_fail++; $display("FAIL prio_after_req1: grant=%b, required 01", g); end
  endtask

  task automatic test_reset_mid();
    logic got = 0;
    step();
    req0_valid = 1; req0_wen = 0; req0_addr = 16'h0030;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (ready0 === 1'b1) got = 1;
      step();
    end
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL rst_mid_grant: no ready0, required grant within 4 cycles"); end
    rst = 1; req0_wen = 1; req0_addr = 16'h0090; req0_wdata = 16'hDEAD;
    model_reset();
    @(negedge clk);
    n_tests++;
    if (all_out !== '0) begin n_fail++; $display("FAIL rst_mid_outputs: got %h, required 0", all_out); end
    step();
    rst = 0; req0_wen = 0; req0_addr = 16'h0031;
    @(negedge clk);
    n_tests++;
    if (ready0 !== 1'b0 || rvalid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_bubble: ready0=%b rvalid0=%b, required 0/0", ready0, rvalid0);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (ready0 !== 1'b1) begin n_fail++; $display("FAIL rst_mid_regrant: ready0=%b, required 1", ready0); end
    note_accepts();
    step();
    req0_valid = 0;
    @(negedge clk);
    n_tests++;
    if (rvalid0 !== 1'b1) begin n_fail++; $display("FAIL rst_mid_rvalid: rvalid0=%b, required 1", rvalid0); end
    step(); step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_read_alone();
    test_write();
    test_round_robin();
    test_sole_owner();
    test_priority();
    test_reset_mid();
    @(negedge clk);
    n_tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: pending q0=%0d q1=%0d, required 0/0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
